// File: rtl/serdes_shiftreg_if.sv
// Bus bundle between a serial link controller and the serdes_shiftreg engine:
// parallel load handshake, bit strobe, serial pins and received-word outputs.
interface serdes_shiftreg_if #(
    parameter int WIDTH = 16
);
    logic             shift_en;
    logic             load_valid;
    logic [WIDTH-1:0] load_data;
    logic             load_ready;
    logic             sout;
    logic             sout_valid;
    logic             sin;
    logic [WIDTH-1:0] rx_data;
    logic             rx_valid;
    logic             busy;

    modport master (
        output shift_en, load_valid, load_data, sin,
        input  load_ready, sout, sout_valid, rx_data, rx_valid, busy
    );

    modport slave (
        input  shift_en, load_valid, load_data, sin,
        output load_ready, sout, sout_valid, rx_data, rx_valid, busy
    );
endinterface

// File: rtl/serdes_shiftreg.sv
// Full-duplex shift-register serdes: shifts a loaded word out on sout while
// assembling a received word from sin on the same shift_en strobes.
module serdes_shiftreg #(
    parameter int   WIDTH     = 16,
    parameter int   LSB_FIRST = 0,
    parameter logic IDLE_BIT  = 1'b0
) (
    input  logic                clk,
    input  logic                clear,
    serdes_shiftreg_if.slave    bus
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state;
    logic [WIDTH-1:0] tx_reg;
    logic [WIDTH-1:0] rx_reg;
    logic [WIDTH-1:0] rx_data_q;
    logic             rx_valid_q;
    logic [CNT_W-1:0] count;

    logic             last_bit;
    logic             accept;
    logic [WIDTH-1:0] rx_next;

    // Move the transmit word one place toward whichever end drives sout.
    function automatic logic [WIDTH-1:0] tx_shift(input logic [WIDTH-1:0] v);
        if (LSB_FIRST != 0)
            return {1'b0, v[WIDTH-1:1]};
        else
            return {v[WIDTH-2:0], 1'b0};
    endfunction

    // The first received bit must end up at the same end the first TX bit came from.
    function automatic logic [WIDTH-1:0] rx_shift(input logic [WIDTH-1:0] v, input logic b);
        if (LSB_FIRST != 0)
            return {b, v[WIDTH-1:1]};
        else
            return {v[WIDTH-2:0], b};
    endfunction

    function automatic logic out_bit(input logic [WIDTH-1:0] v);
        if (LSB_FIRST != 0)
            return v[0];
        else
            return v[WIDTH-1];
    endfunction

    assign last_bit = (state == SHIFT) && (count == LAST) && bus.shift_en;
    assign accept   = bus.load_valid && bus.load_ready;
    assign rx_next  = rx_shift(rx_reg, bus.sin);

    assign bus.load_ready = !clear && ((state == IDLE) || last_bit);
    assign bus.sout       = (state == SHIFT) ? out_bit(tx_reg) : IDLE_BIT;
    assign bus.sout_valid = (state == SHIFT);
    assign bus.busy       = (state == SHIFT);
    assign bus.rx_data    = rx_data_q;
    assign bus.rx_valid   = rx_valid_q;

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state      <= IDLE;
            tx_reg     <= '0;
            rx_reg     <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            count      <= '0;
        end else begin
            rx_valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        tx_reg <= bus.load_data;
                        count  <= '0;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (bus.shift_en) begin
                        if (count == LAST) begin
                            rx_data_q  <= rx_next;
                            rx_valid_q <= 1'b1;
                            rx_reg     <= '0;
                            count      <= '0;
                            // A word offered on the final strobe starts the next frame with no gap.
                            if (bus.load_valid) begin
                                tx_reg <= bus.load_data;
                            end else begin
                                tx_reg <= tx_shift(tx_reg);
                                state  <= IDLE;
                            end
                        end else begin
                            tx_reg <= tx_shift(tx_reg);
                            rx_reg <= rx_next;
                            count  <= count + CNT_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serdes_shiftreg.sv
// Scoreboard bench for serdes_shiftreg: a 16-bit MSB-first instance and an
// 8-bit LSB-first instance with idle-high line, both in sin/sout loopback.
module tb_serdes_shiftreg;
    logic clk;
    logic clear;
    logic loop_a;
    logic loop_b;

    int n_cmp;
    int n_err;

    logic [15:0] qa[$];
    logic [7:0]  qb[$];

    serdes_shiftreg_if #(.WIDTH(16)) bus_a ();
    serdes_shiftreg_if #(.WIDTH(8))  bus_b ();

    assign bus_a.sin = loop_a ? bus_a.sout : 1'b0;
    assign bus_b.sin = loop_b ? bus_b.sout : 1'b0;

    serdes_shiftreg #(.WIDTH(16), .LSB_FIRST(0), .IDLE_BIT(1'b0)) dut_a (
        .clk(clk), .clear(clear), .bus(bus_a.slave)
    );
    serdes_shiftreg #(.WIDTH(8), .LSB_FIRST(1), .IDLE_BIT(1'b1)) dut_b (
        .clk(clk), .clear(clear), .bus(bus_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        @(negedge clk);
        bus_a.shift_en = 1'b1;
        bus_b.shift_en = 1'b1;
        #3 clear = 1'b1;
        #1;
        n_cmp++; if (bus_a.sout !== 1'b0) begin n_err++; $display("FAIL reset_sout_a got=%b exp=0", bus_a.sout); end
        n_cmp++; if (bus_a.sout_valid !== 1'b0) begin n_err++; $display("FAIL reset_sout_valid_a got=%b exp=0", bus_a.sout_valid); end
        n_cmp++; if (bus_a.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy_a got=%b exp=0", bus_a.busy); end
        n_cmp++; if (bus_a.load_ready !== 1'b0) begin n_err++; $display("FAIL reset_load_ready_a got=%b exp=0", bus_a.load_ready); end
        n_cmp++; if (bus_a.rx_valid !== 1'b0) begin n_err++; $display("FAIL reset_rx_valid_a got=%b exp=0", bus_a.rx_valid); end
        n_cmp++; if (bus_a.rx_data !== 16'h0000) begin n_err++; $display("FAIL reset_rx_data_a got=%h exp=0000", bus_a.rx_data); end
        n_cmp++; if (bus_b.sout !== 1'b1) begin n_err++; $display("FAIL reset_sout_b got=%b exp=1", bus_b.sout); end
        n_cmp++; if (bus_b.load_ready !== 1'b0) begin n_err++; $display("FAIL reset_load_ready_b got=%b exp=0", bus_b.load_ready); end
        @(negedge clk);
        clear = 1'b0;
        #1;
        n_cmp++; if (bus_a.load_ready !== 1'b1) begin n_err++; $display("FAIL release_load_ready_a got=%b exp=1", bus_a.load_ready); end
        n_cmp++; if (bus_b.load_ready !== 1'b1) begin n_err++; $display("FAIL release_load_ready_b got=%b exp=1", bus_b.load_ready); end
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            n_cmp++;
            if (bus_a.rx_valid !== 1'b0 || bus_b.rx_valid !== 1'b0) begin
                n_err++; $display("FAIL reset_no_rx_valid cycle=%0d got=%b%b exp=00", c, bus_a.rx_valid, bus_b.rx_valid);
            end
        end
    endtask

    // One complete MSB-first loopback frame on the 16-bit instance.
    task automatic test_msb_loopback(input logic [15:0] word);
        @(negedge clk);
        loop_a = 1'b1;
        bus_a.shift_en = 1'b1;
        n_cmp++; if (bus_a.load_ready !== 1'b1) begin n_err++; $display("FAIL frame_idle_ready got=%b exp=1", bus_a.load_ready); end
        bus_a.load_valid = 1'b1;
        bus_a.load_data  = word;
        qa.push_back(word);
        @(negedge clk);
        bus_a.load_valid = 1'b0;
        bus_a.load_data  = 16'h0000;
        for (int k = 0; k < 16; k++) begin
            n_cmp++;
            if (bus_a.sout_valid !== 1'b1 || bus_a.sout !== word[15-k] || bus_a.rx_valid !== 1'b0) begin
                n_err++; $display("FAIL frame_bit word=%h k=%0d got v=%b s=%b rv=%b exp v=1 s=%b rv=0",
                                  word, k, bus_a.sout_valid, bus_a.sout, bus_a.rx_valid, word[15-k]);
            end
            @(negedge clk);
        end
        n_cmp++;
        if (bus_a.rx_valid !== 1'b1) begin
            n_err++; $display("FAIL frame_rx_valid word=%h got=%b exp=1", word, bus_a.rx_valid);
        end else if (qa.size() == 0) begin
            n_err++; $display("FAIL frame_queue_empty got=rx_valid exp=no output");
        end else begin
            logic [15:0] e;
            e = qa.pop_front();
            if (bus_a.rx_data !== e) begin n_err++; $display("FAIL frame_rx_data got=%h exp=%h", bus_a.rx_data, e); end
        end
        n_cmp++; if (bus_a.sout_valid !== 1'b0 || bus_a.sout !== 1'b0) begin
            n_err++; $display("FAIL frame_back_idle got v=%b s=%b exp v=0 s=0", bus_a.sout_valid, bus_a.sout);
        end
        @(negedge clk);
        n_cmp++; if (bus_a.rx_valid !== 1'b0) begin n_err++; $display("FAIL frame_rx_pulse_len got=%b exp=0", bus_a.rx_valid); end
    endtask

    task automatic test_reset_mid_frame();
        logic [15:0] word;
        word = 16'hBEEF;
        @(negedge clk);
        loop_a = 1'b1;
        bus_a.shift_en   = 1'b1;
        bus_a.load_valid = 1'b1;
        bus_a.load_data  = word;
        @(negedge clk);
        bus_a.load_valid = 1'b0;
        repeat (7) @(negedge clk);
        n_cmp++; if (bus_a.sout_valid !== 1'b1 || bus_a.sout !== word[8]) begin
            n_err++; $display("FAIL midreset_before got v=%b s=%b exp v=1 s=%b", bus_a.sout_valid, bus_a.sout, word[8]);
        end
        #2 clear = 1'b1;
        #1;
        n_cmp++; if (bus_a.sout_valid !== 1'b0 || bus_a.sout !== 1'b0 || bus_a.load_ready !== 1'b0) begin
            n_err++; $display("FAIL midreset_during got v=%b s=%b r=%b exp 0 0 0", bus_a.sout_valid, bus_a.sout, bus_a.load_ready);
        end
        n_cmp++; if (bus_a.rx_data !== 16'h0000) begin n_err++; $display("FAIL midreset_rx_data got=%h exp=0000", bus_a.rx_data); end
        @(negedge clk);
        clear = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            n_cmp++;
            if (bus_a.rx_valid !== 1'b0 || bus_a.sout_valid !== 1'b0 || bus_a.rx_data !== 16'h0000) begin
                n_err++; $display("FAIL midreset_after c=%0d got rv=%b v=%b d=%h exp 0 0 0000",
                                  c, bus_a.rx_valid, bus_a.sout_valid, bus_a.rx_data);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] w0;
        logic [15:0] w1;
        logic [15:0] cur;
        int pulses;
        w0 = 16'h1234;
        w1 = 16'hFFFF;
        pulses = 0;
        @(negedge clk);
        loop_a = 1'b1;
        bus_a.shift_en   = 1'b1;
        bus_a.load_valid = 1'b1;
        bus_a.load_data  = w0;
        qa.push_back(w0);
        @(negedge clk);
        bus_a.load_data = w1;
        qa.push_back(w1);
        for (int k = 0; k <= 32; k++) begin
            cur = (k < 16) ? w0 : w1;
            if (k < 32) begin
                n_cmp++;
                if (bus_a.sout_valid !== 1'b1 || bus_a.sout !== cur[15-(k%16)]) begin
                    n_err++; $display("FAIL b2b_bit k=%0d got v=%b s=%b exp v=1 s=%b", k, bus_a.sout_valid, bus_a.sout, cur[15-(k%16)]);
                end
            end
            if (k == 15 || k == 31) begin
                n_cmp++; if (bus_a.load_ready !== 1'b1) begin n_err++; $display("FAIL b2b_last_ready k=%0d got=%b exp=1", k, bus_a.load_ready); end
            end
            n_cmp++;
            if (bus_a.rx_valid !== ((k == 16) || (k == 32))) begin
                n_err++; $display("FAIL b2b_rx_valid k=%0d got=%b exp=%b", k, bus_a.rx_valid, (k == 16) || (k == 32));
            end
            if (bus_a.rx_valid === 1'b1) begin
                pulses++;
                n_cmp++;
                if (qa.size() == 0) begin
                    n_err++; $display("FAIL b2b_queue_empty got=rx_valid exp=no output");
                end else begin
                    logic [15:0] e;
                    e = qa.pop_front();
                    if (bus_a.rx_data !== e) begin n_err++; $display("FAIL b2b_rx_data got=%h exp=%h", bus_a.rx_data, e); end
                end
            end
            if (k == 16) bus_a.load_valid = 1'b0;
            @(negedge clk);
        end
        n_cmp++; if (pulses != 2) begin n_err++; $display("FAIL b2b_pulses got=%0d exp=2", pulses); end
        n_cmp++; if (bus_a.sout_valid !== 1'b0) begin n_err++; $display("FAIL b2b_idle got=%b exp=0", bus_a.sout_valid); end
    endtask

    task automatic test_stall();
        logic [15:0] word;
        int strobes;
        bit got;
        bit se;
        word = 16'h8001;
        strobes = 0;
        got = 1'b0;
        @(negedge clk);
        loop_a = 1'b1;
        bus_a.shift_en   = 1'b0;
        bus_a.load_valid = 1'b1;
        bus_a.load_data  = word;
        qa.push_back(word);
        @(negedge clk);
        bus_a.load_valid = 1'b0;
        for (int c = 0; c < 100 && !got; c++) begin
            if (bus_a.rx_valid === 1'b1) begin
                got = 1'b1;
                n_cmp++; if (strobes != 16) begin n_err++; $display("FAIL stall_strobes got=%0d exp=16", strobes); end
                n_cmp++;
                if (qa.size() == 0) begin
                    n_err++; $display("FAIL stall_queue_empty got=rx_valid exp=no output");
                end else begin
                    logic [15:0] e;
                    e = qa.pop_front();
                    if (bus_a.rx_data !== e) begin n_err++; $display("FAIL stall_rx_data got=%h exp=%h", bus_a.rx_data, e); end
                end
            end else if (strobes < 16) begin
                n_cmp++;
                if (bus_a.sout_valid !== 1'b1 || bus_a.sout !== word[15-strobes]) begin
                    n_err++; $display("FAIL stall_bit c=%0d got v=%b s=%b exp v=1 s=%b", c, bus_a.sout_valid, bus_a.sout, word[15-strobes]);
                end
            end
            se = ((c % 3) == 0);
            bus_a.shift_en = se;
            @(negedge clk);
            if (se && !got) strobes++;
        end
        n_cmp++; if (!got) begin n_err++; $display("FAIL stall_timeout got=no rx_valid exp=rx_valid"); end
        bus_a.shift_en = 1'b1;
    endtask

    task automatic test_lsb_variant();
        logic [7:0] word;
        word = 8'h96;
        @(negedge clk);
        loop_b = 1'b1;
        bus_b.shift_en   = 1'b1;
        bus_b.load_valid = 1'b1;
        bus_b.load_data  = word;
        qb.push_back(word);
        @(negedge clk);
        bus_b.load_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            n_cmp++;
            if (bus_b.sout_valid !== 1'b1 || bus_b.sout !== word[k]) begin
                n_err++; $display("FAIL lsb_bit k=%0d got v=%b s=%b exp v=1 s=%b", k, bus_b.sout_valid, bus_b.sout, word[k]);
            end
            @(negedge clk);
        end
        n_cmp++;
        if (bus_b.rx_valid !== 1'b1) begin
            n_err++; $display("FAIL lsb_rx_valid got=%b exp=1", bus_b.rx_valid);
        end else if (qb.size() == 0) begin
            n_err++; $display("FAIL lsb_queue_empty got=rx_valid exp=no output");
        end else begin
            logic [7:0] e;
            e = qb.pop_front();
            if (bus_b.rx_data !== e) begin n_err++; $display("FAIL lsb_rx_data got=%h exp=%h", bus_b.rx_data, e); end
        end
        n_cmp++; if (bus_b.sout !== 1'b1 || bus_b.sout_valid !== 1'b0) begin
            n_err++; $display("FAIL lsb_idle got s=%b v=%b exp s=1 v=0", bus_b.sout, bus_b.sout_valid);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        loop_a = 1'b0;
        loop_b = 1'b0;
        clear = 1'b1;
        bus_a.shift_en = 1'b0; bus_a.load_valid = 1'b0; bus_a.load_data = '0;
        bus_b.shift_en = 1'b0; bus_b.load_valid = 1'b0; bus_b.load_data = '0;
        repeat (2) @(negedge clk);
        clear = 1'b0;

        test_reset();
        test_reset_mid_frame();
        test_msb_loopback(16'h0F0F);
        test_msb_loopback(16'hA5C3);
        test_back_to_back();
        test_stall();
        test_lsb_variant();

        n_cmp++; if (qa.size() != 0 || qb.size() != 0) begin
            n_err++; $display("FAIL scoreboard_leftover got=%0d/%0d exp=0/0", qa.size(), qb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
